// File: rtl/noc_pkg.sv
// Shared NoC types: arbiter FSM states and flit type encodings.
package noc_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      TYPE_HEAD     = 2'b00,
      TYPE_BODY     = 2'b01,
      TYPE_TAIL     = 2'b10,
      TYPE_HEADTAIL = 2'b11
   } flit_type_e;

endpackage

// File: rtl/output_arbiter_if.sv
// Request/grant bundle between the input VCs and one output port arbiter.
interface output_arbiter_if #(
   parameter int REQ_N = 4,
   parameter int IDX_W = $clog2(REQ_N)
);
   logic [REQ_N-1:0] req_i;
   logic [REQ_N-1:0] send_i;
   logic [REQ_N-1:0] tail_i;
   logic             rdy_i;
   logic [REQ_N-1:0] grt_o;
   logic [IDX_W-1:0] grt_idx_o;
   logic             lck_o;
   logic             err_o;

   modport master (
      output req_i, send_i, tail_i, rdy_i,
      input  grt_o, grt_idx_o, lck_o, err_o
   );

   modport slave (
      input  req_i, send_i, tail_i, rdy_i,
      output grt_o, grt_idx_o, lck_o, err_o
   );
endinterface

// File: rtl/output_arbiter_rr_pick.sv
// Combinational round-robin search: first set request strictly after ptr, wrapping.
module rr_pick #(
   parameter int REQ_N = 4,
   parameter int IDX_W = $clog2(REQ_N)
) (
   input  logic [REQ_N-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [REQ_N-1:0] onehot,
   output logic [IDX_W-1:0] idx,
   output logic             any
);
   logic [IDX_W-1:0] j;

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      j      = '0;
      for (int i = 1; i <= REQ_N; i++) begin
         j = IDX_W'((int'(ptr) + i) % REQ_N);
         if (!any && req[j]) begin
            any       = 1'b1;
            idx       = j;
            onehot[j] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/output_arbiter.sv
// Round-robin output port arbiter, packet-locked, registered grant one cycle after request.
// rdy_i low freezes the stall timer so a backpressured owner keeps the port indefinitely.
module output_arbiter
   import noc_pkg::*;
#(
   parameter int REQ_N   = 4,
   parameter int TIMEOUT = 64,
   parameter int IDX_W   = $clog2(REQ_N)
) (
   input logic             clk,
   input logic             rst,
   output_arbiter_if.slave arb
);
   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_e       state, state_n;
   logic [REQ_N-1:0] grt_q, grt_n;
   logic [IDX_W-1:0] idx_q, idx_n;
   logic [IDX_W-1:0] ptr_q, ptr_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             err_q, err_n;

   logic [REQ_N-1:0] pick_oh;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             own_send, own_tail, own_req, stalled, stall_hit;

   assign own_send  = arb.send_i[idx_q];
   assign own_tail  = arb.tail_i[idx_q];
   assign own_req   = arb.req_i[idx_q];
   assign stalled   = arb.rdy_i && !own_send;
   assign stall_hit = stalled && (cnt_q >= CNT_LAST);

   // Masking with grt_q drops the owner's own request on handover; in IDLE grt_q is zero.
   rr_pick #(.REQ_N(REQ_N), .IDX_W(IDX_W)) u_pick (
      .req    (arb.req_i & ~grt_q),
      .ptr    ((state == ST_HOLD) ? idx_q : ptr_q),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      state_n = state;
      grt_n   = grt_q;
      idx_n   = idx_q;
      ptr_n   = ptr_q;
      cnt_n   = cnt_q;
      err_n   = err_q | (|(arb.send_i & ~grt_q));
      if (state == ST_IDLE) begin
         cnt_n = '0;
         if (pick_any) begin
            state_n = ST_HOLD;
            grt_n   = pick_oh;
            idx_n   = pick_idx;
         end
      end else if (own_send && own_tail) begin
         ptr_n = idx_q;
         cnt_n = '0;
         if (pick_any) begin
            grt_n = pick_oh;
            idx_n = pick_idx;
         end else begin
            state_n = ST_IDLE;
            grt_n   = '0;
            idx_n   = '0;
         end
      end else if (!own_req || stall_hit) begin
         state_n = ST_IDLE;
         grt_n   = '0;
         idx_n   = '0;
         ptr_n   = idx_q;
         cnt_n   = '0;
         err_n   = 1'b1;
      end else if (own_send) begin
         cnt_n = '0;
      end else if (stalled && cnt_q != CNT_MAX) begin
         cnt_n = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         grt_q <= '0;
         idx_q <= '0;
         ptr_q <= IDX_W'(REQ_N - 1);
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_n;
         grt_q <= grt_n;
         idx_q <= idx_n;
         ptr_q <= ptr_n;
         cnt_q <= cnt_n;
         err_q <= err_n;
      end
   end

   assign arb.grt_o     = grt_q;
   assign arb.grt_idx_o = idx_q;
   assign arb.lck_o     = (state == ST_HOLD);
   assign arb.err_o     = err_q;
endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter (REQ_N=4, TIMEOUT=8) with an expectation queue.
module tb_output_arbiter;
   logic clk;
   logic rst;

   output_arbiter_if #(.REQ_N(4)) arb_if ();

   output_arbiter #(.REQ_N(4), .TIMEOUT(8)) dut (
      .clk (clk),
      .rst (rst),
      .arb (arb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [3:0] grt;
      logic [1:0] idx;
      logic       lck;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic push_exp(input string tag, input logic [3:0] g, input logic [1:0] i,
                           input logic l, input logic e);
      exp_t x;
      x.tag = tag;
      x.grt = g;
      x.idx = i;
      x.lck = l;
      x.err = e;
      sb.push_back(x);
   endtask

   task automatic compare_head();
      exp_t x;
      x = sb.pop_front();
      vectors++;
      assert (arb_if.grt_o === x.grt) else begin
         miscompares++;
         $error("FAIL %s grt_o observed=%b expected=%b", x.tag, arb_if.grt_o, x.grt);
      end
      vectors++;
      assert (arb_if.grt_idx_o === x.idx) else begin
         miscompares++;
         $error("FAIL %s grt_idx_o observed=%0d expected=%0d", x.tag, arb_if.grt_idx_o, x.idx);
      end
      vectors++;
      assert (arb_if.lck_o === x.lck) else begin
         miscompares++;
         $error("FAIL %s lck_o observed=%b expected=%b", x.tag, arb_if.lck_o, x.lck);
      end
      vectors++;
      assert (arb_if.err_o === x.err) else begin
         miscompares++;
         $error("FAIL %s err_o observed=%b expected=%b", x.tag, arb_if.err_o, x.err);
      end
   endtask

   // Expectation for the state after the next rising edge.
   task automatic step(input string tag, input logic [3:0] g, input logic [1:0] i,
                       input logic l, input logic e);
      push_exp(tag, g, i, l, e);
      @(posedge clk);
      #1;
      compare_head();
   endtask

   // Expectation checked without any clock edge (asynchronous reset).
   task automatic check_now(input string tag, input logic [3:0] g, input logic [1:0] i,
                            input logic l, input logic e);
      push_exp(tag, g, i, l, e);
      #1;
      compare_head();
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] s, input logic [3:0] t,
                        input logic rd);
      arb_if.req_i  = r;
      arb_if.send_i = s;
      arb_if.tail_i = t;
      arb_if.rdy_i  = rd;
   endtask

   initial begin
      rst = 1'b1;
      drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
      #12;
      check_now("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // First arbitration after reset: VC0 has priority, but only VC1/VC3 request.
      drive(4'b1010, 4'b0000, 4'b0000, 1'b1);
      step("grant_vc1", 4'b0010, 2'd1, 1'b1, 1'b0);

      // Three-flit packet from VC1 with all VCs requesting.
      drive(4'b1111, 4'b0010, 4'b0000, 1'b1);
      step("pkt_flit1", 4'b0010, 2'd1, 1'b1, 1'b0);
      step("pkt_flit2", 4'b0010, 2'd1, 1'b1, 1'b0);
      drive(4'b1111, 4'b0010, 4'b0010, 1'b1);
      step("pkt_tail_handover", 4'b0100, 2'd2, 1'b1, 1'b0);

      // VC2 alone, single HEADTAIL flit, then idle and regrant.
      drive(4'b0100, 4'b0100, 4'b0100, 1'b1);
      step("headtail_release", 4'b0000, 2'd0, 1'b0, 1'b0);
      drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
      step("idle_no_req", 4'b0000, 2'd0, 1'b0, 1'b0);
      drive(4'b0100, 4'b0000, 4'b0000, 1'b1);
      step("regrant_vc2", 4'b0100, 2'd2, 1'b1, 1'b0);

      // Downstream not ready: grant held with no timeout.
      drive(4'b0100, 4'b0000, 4'b0000, 1'b0);
      for (int k = 0; k < 20; k++) step("rdy0_hold", 4'b0100, 2'd2, 1'b1, 1'b0);

      // Ready but owner idle: forced release on the eighth stalled cycle.
      drive(4'b0100, 4'b0000, 4'b0000, 1'b1);
      for (int k = 0; k < 7; k++) step("stall_pre_timeout", 4'b0100, 2'd2, 1'b1, 1'b0);
      step("timeout_release", 4'b0000, 2'd0, 1'b0, 1'b1);
      drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
      step("err_sticky", 4'b0000, 2'd0, 1'b0, 1'b1);

      rst = 1'b1;
      check_now("reset_clears_err", 4'b0000, 2'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Non-owner send while VC0 owns the port.
      drive(4'b0001, 4'b0000, 4'b0000, 1'b1);
      step("grant_vc0", 4'b0001, 2'd0, 1'b1, 1'b0);
      drive(4'b0001, 4'b0100, 4'b0000, 1'b1);
      step("nonowner_send", 4'b0001, 2'd0, 1'b1, 1'b1);
      drive(4'b0001, 4'b0000, 4'b0000, 1'b1);
      step("nonowner_hold", 4'b0001, 2'd0, 1'b1, 1'b1);

      // Reset mid-packet, then all VCs request: VC0 wins.
      rst = 1'b1;
      check_now("async_reset_midpkt", 4'b0000, 2'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(4'b1111, 4'b0000, 4'b0000, 1'b1);
      step("post_reset_vc0", 4'b0001, 2'd0, 1'b1, 1'b0);

      // Owner drops its request without a tail: abort with error.
      drive(4'b1110, 4'b0000, 4'b0000, 1'b1);
      step("abort_release", 4'b0000, 2'd0, 1'b0, 1'b1);
      step("after_abort_vc1", 4'b0010, 2'd1, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/output_arbiter.md
OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 Parameter REQ_N, default 4: number of requesting input VCs sharing one output port.
REQ-002 Parameter TIMEOUT, default 64: cycles the port may be held without progress before forced release.
REQ-003 Parameter IDX_W, default $clog2(REQ_N): width of the winner index.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req_i  input  REQ_N  per-VC request, held from head until tail transfer.
REQ-008 send_i  input  REQ_N  per-VC flit transferred through the switch this cycle.
REQ-009 tail_i  input  REQ_N  per-VC: flit on send_i is TYPE_TAIL or TYPE_HEADTAIL.
REQ-010 rdy_i  input  1  downstream VC can accept a flit.
REQ-011 grt_o  output  REQ_N  one-hot grant, registered.
REQ-012 grt_idx_o  output  IDX_W  index of the granted VC; valid while lck_o=1.
REQ-013 lck_o  output  1  port held by a packet.
REQ-014 err_o  output  1  sticky protocol/timeout error.

Function
REQ-015 FSM states: IDLE (no owner) and HOLD (owner = grt_idx_o).
REQ-016 IDLE, any req_i bit set: round-robin winner searched from ptr+1 upward, wrapping modulo REQ_N; next cycle grt_o=onehot(winner), lck_o=1, state HOLD; one-cycle grant latency.
REQ-017 IDLE, req_i=0: outputs stay 0.
REQ-018 HOLD: grt_o stays constant regardless of other req_i bits; no preemption.
REQ-019 HOLD, send_i[owner]=1 and tail_i[owner]=1: ptr<=owner; if other requests exist (owner's own req_i ignored in that cycle), grant passes to next RR winner next cycle with no bubble, otherwise return to IDLE with grt_o=0.
REQ-020 HOLD, req_i[owner] drops without a tail transfer: abort, ptr<=owner, return to IDLE, err_o<=1.
REQ-021 send_i asserted by any non-owner VC, or while IDLE: err_o<=1; state unaffected.
REQ-022 Stall counter, clog2(TIMEOUT+1) bits, counts HOLD cycles with rdy_i=1 and send_i[owner]=0; cleared on any owner send, on leaving HOLD, and on grant change.
REQ-023 Stall counter reaching TIMEOUT: forced release as REQ-020, err_o<=1; counter saturates, never wraps.
REQ-024 rdy_i=0 pauses the stall counter; the grant is held indefinitely.
REQ-025 ptr initial value REQ_N-1, so VC0 has first priority after reset.
REQ-026 err_o clears only on reset.

Reset
REQ-027 rst=1 asynchronously forces IDLE, grt_o=0, grt_idx_o=0, lck_o=0, err_o=0, stall counter=0, ptr=REQ_N-1.
REQ-028 Reset mid-packet drops the grant immediately; first arbitration occurs on the first clk edge after rst deasserts.

Structure
REQ-029 The FSM state enum and TYPE_* flit encodings SHALL reside in noc_pkg; REQ_N and TIMEOUT stay module parameters.
REQ-030 The round-robin priority search SHALL be a combinational sub-module rr_pick (inputs req, ptr; outputs onehot, idx, any).
REQ-031 The target size is 150-250 lines of RTL.

Verification (REQ_N=4, TIMEOUT=8)
REQ-032 After reset, req_i=4'b1010 -> next cycle grt_o=4'b0010, grt_idx_o=1, lck_o=1.
REQ-033 VC1 holds the grant, req_i=4'b1111, three-flit packet with tail on the third send -> cycle after tail grt_o=4'b0100; VC0 and VC3 never granted during the packet.
REQ-034 Only VC2 requests, single HEADTAIL send -> IDLE next cycle, grt_o=0, lck_o=0; a later VC2 request is granted again.
REQ-035 Owner with rdy_i=1 and no send for 8 cycles -> release, err_o=1, lck_o=0; with rdy_i=0 for 20 cycles -> grant held, err_o=0.
REQ-036 send_i=4'b0100 while VC0 owns the port -> err_o=1, grt_o unchanged.
REQ-037 rst pulsed mid-packet -> all outputs 0 asynchronously; after release req_i=4'b1111 grants VC0.
